fpu_dispatch_ctrl: RTL and testbench
====================================

Name: fpu_dispatch_ctrl

Overview:
Parametrised successor to the single-op FPU controller. Accepts tagged commands over a valid/ready handshake and dispatches each to its functional unit (add_sub, mul, div, sin/cos, log, exp, sqrt). Different units run concurrently, and results retire out of order with their tag. Also adds per-unit timeout, error reporting for illegal opcodes, and output backpressure. Sits between the host command interface and the FPU unit array.

Parameters:
PRECISION_LEN, 64, operand/result width (IEEE-754)
OP_LEN, 4, opcode width
TAG_LEN, 4, command tag width
NUM_UNITS, 7, functional units (0 addsub, 1 mul, 2 div, 3 sincos, 4 log, 5 exp, 6 sqrt)
TIMEOUT, 63, max RUN cycles before a unit is declared hung; counter width = $clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
srst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  OP_LEN  opcode (IDLE 0, ADD 1, SUB 2, MUL 3, DIV 4, SIN 5, COS 6, LOG 7, EXP 8, SQR 9)
cmd_tag  in  TAG_LEN  returned unchanged with the result
cmd_a, cmd_b  in  PRECISION_LEN each  operands
unit_enable  out  NUM_UNITS  one-cycle start pulse per unit
unit_op  out  OP_LEN  registered opcode (add_n / sin-cos select)
unit_a, unit_b  out  PRECISION_LEN each  registered operands
unit_valid  in  NUM_UNITS  one-cycle completion pulse per unit
unit_result  in  NUM_UNITS*PRECISION_LEN  packed results, unit i at [i*PRECISION_LEN +: PRECISION_LEN]
res_valid  out  1  result available
res_ready  in  1  consumer accepts
res_data  out  PRECISION_LEN  result
res_tag  out  TAG_LEN  tag of the command
res_op  out  OP_LEN  opcode of the command
res_err  out  1  timeout or illegal opcode
busy  out  NUM_UNITS  slot not IDLE

Behaviour:
- Slots: one per unit, plus error slot E (index NUM_UNITS) for illegal opcodes 10..15.
- Each slot stores tag, op and result, and runs an FSM: IDLE -> RUN -> HOLD -> IDLE. Slot E goes IDLE -> HOLD directly.
- cmd_ready = !srst && (op==IDLE || target slot in IDLE). Decoded combinationally from cmd_op and registered slot state.
- Op IDLE: accepted and dropped; no response.
- Accept at cycle T:
  - Operands and op registered at T+1.
  - unit_enable[u] pulses at T+1; slot enters RUN with timer=0.
  - unit_a/b/op hold their value until the next issue.
- RUN:
  - Timer increments each cycle.
  - unit_valid[u] captures the result, err=0, and moves the slot to HOLD (res_valid no earlier than the cycle after unit_valid).
  - If the timer reaches TIMEOUT with no valid: HOLD, err=1, result=64'h7FF8_0000_0000_0000 (qNaN).
  - unit_valid outside RUN is ignored.
- Illegal op: slot E -> HOLD at T+1 with err=1 and qNaN. cmd_ready for illegal ops requires slot E IDLE.
- Output arbitration:
  - Round-robin over slots in HOLD, starting at rr_ptr.
  - res_* reflect the granted slot and stay stable while res_valid && !res_ready.
  - On handshake: granted slot -> IDLE, rr_ptr = grant+1 (mod NUM_UNITS+1).
- A drained slot may accept a new command no earlier than the next cycle (no same-cycle drain+accept).
- Simultaneous unit_valid from several units: all captured the same cycle; output order by round-robin.
- Reset:
  - All slots IDLE; timers, rr_ptr and stored fields 0.
  - unit_enable=0, res_valid=0, res_*=0, busy=0, cmd_ready=0.
  - Reset mid-operation aborts without a response; late unit_valid after reset is ignored.

Decomposition:
- Package fpu_pkg: opcode localparams (IDLE..SQR), unit index constants, op->unit mapping function, QNAN constant, is_legal_op function.
- Sub-module fpu_slot: FSM, timer, stored tag/op/result/err, instantiated NUM_UNITS+1 times (error slot with RUN disabled).
- Arbiter: inline in fpu_dispatch_ctrl.

Test Plan:
- ADD a=1.0 b=2.0 tag=3; unit 0 valid 2 cycles after enable with 0x4008000000000000 -> res_valid, res_data=0x4008000000000000, tag=3, op=1, err=0.
- DIV tag=1, then MUL tag=2 next cycle; mul returns first -> MUL result out before DIV; busy[2] high throughout.
- Second DIV while div in RUN -> cmd_ready=0 until slot drained; accepted the cycle after res handshake.
- DIV with unit_valid never asserted -> after TIMEOUT+1 cycles res_err=1, res_data=0x7FF8000000000000, busy[2] clears on handshake.
- Opcode 12 tag=5 -> res_valid at T+1, err=1, op=12. Opcode 0 -> accepted, no result.
- SIN, LOG, SQR complete the same cycle with res_ready=0 for 5 cycles -> outputs stable, then drained in round-robin order; srst mid-RUN -> no output, all busy=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared opcode, unit-index and slot-state definitions for the FPU dispatch controller.
package fpu_pkg;

  localparam logic [3:0] OP_IDLE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_SIN  = 4'd5;
  localparam logic [3:0] OP_COS  = 4'd6;
  localparam logic [3:0] OP_LOG  = 4'd7;
  localparam logic [3:0] OP_EXP  = 4'd8;
  localparam logic [3:0] OP_SQR  = 4'd9;

  localparam logic [2:0] U_ADDSUB = 3'd0;
  localparam logic [2:0] U_MUL    = 3'd1;
  localparam logic [2:0] U_DIV    = 3'd2;
  localparam logic [2:0] U_SINCOS = 3'd3;
  localparam logic [2:0] U_LOG    = 3'd4;
  localparam logic [2:0] U_EXP    = 3'd5;
  localparam logic [2:0] U_SQRT   = 3'd6;
  localparam logic [2:0] U_ERR    = 3'd7;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } slot_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_SQR;
  endfunction

  function automatic logic [2:0] op_to_unit(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB: return U_ADDSUB;
      OP_MUL:         return U_MUL;
      OP_DIV:         return U_DIV;
      OP_SIN, OP_COS: return U_SINCOS;
      OP_LOG:         return U_LOG;
      OP_EXP:         return U_EXP;
      OP_SQR:         return U_SQRT;
      default:        return U_ERR;
    endcase
  endfunction

endpackage

// File: rtl/fpu_slot.sv
// One result slot: tracks an in-flight command, its run timer, and the result awaiting drain.
//   state  | meaning
//   S_IDLE | free, may accept a command
//   S_RUN  | unit started, waiting for completion or timeout
//   S_HOLD | result (or error) stored, waiting for output handshake
module fpu_slot
  import fpu_pkg::*;
#(
  parameter int PRECISION_LEN = 64,
  parameter int OP_LEN        = 4,
  parameter int TAG_LEN       = 4,
  parameter int TIMEOUT       = 63,
  parameter bit HAS_RUN       = 1'b1
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     start,
  input  logic [TAG_LEN-1:0]       start_tag,
  input  logic [OP_LEN-1:0]        start_op,
  input  logic                     unit_valid,
  input  logic [PRECISION_LEN-1:0] unit_result,
  input  logic                     drain,
  output logic                     idle,
  output logic                     hold,
  output logic [TAG_LEN-1:0]       tag,
  output logic [OP_LEN-1:0]        op,
  output logic [PRECISION_LEN-1:0] result,
  output logic                     err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  slot_state_e    state, state_nxt;
  logic [TW-1:0]  timer;
  logic           timed_out;

  assign timed_out = (timer == TW'(TIMEOUT));
  assign idle      = (state == S_IDLE);
  assign hold      = (state == S_HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = HAS_RUN ? S_RUN : S_HOLD;
      S_RUN:   if (unit_valid || timed_out) state_nxt = S_HOLD;
      S_HOLD:  if (drain) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state  <= S_IDLE;
      timer  <= '0;
      tag    <= '0;
      op     <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          tag   <= start_tag;
          op    <= start_op;
          timer <= '0;
          if (!HAS_RUN) begin
            result <= PRECISION_LEN'(QNAN);
            err    <= 1'b1;
          end
        end
        S_RUN: begin
          // a completion on the final timer cycle still wins over the timeout
          if (unit_valid) begin
            result <= unit_result;
            err    <= 1'b0;
          end else if (timed_out) begin
            result <= PRECISION_LEN'(QNAN);
            err    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fpu_dispatch_ctrl.sv
// Tagged command dispatcher for the FPU unit array with out-of-order, round-robin result retirement.
module fpu_dispatch_ctrl
  import fpu_pkg::*;
#(
  parameter int PRECISION_LEN = 64,
  parameter int OP_LEN        = 4,
  parameter int TAG_LEN       = 4,
  parameter int NUM_UNITS     = 7,
  parameter int TIMEOUT       = 63
) (
  input  logic                               clk,
  input  logic                               srst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [OP_LEN-1:0]                  cmd_op,
  input  logic [TAG_LEN-1:0]                 cmd_tag,
  input  logic [PRECISION_LEN-1:0]           cmd_a,
  input  logic [PRECISION_LEN-1:0]           cmd_b,
  output logic [NUM_UNITS-1:0]               unit_enable,
  output logic [OP_LEN-1:0]                  unit_op,
  output logic [PRECISION_LEN-1:0]           unit_a,
  output logic [PRECISION_LEN-1:0]           unit_b,
  input  logic [NUM_UNITS-1:0]               unit_valid,
  input  logic [NUM_UNITS*PRECISION_LEN-1:0] unit_result,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [PRECISION_LEN-1:0]           res_data,
  output logic [TAG_LEN-1:0]                 res_tag,
  output logic [OP_LEN-1:0]                  res_op,
  output logic                               res_err,
  output logic [NUM_UNITS-1:0]               busy
);

  localparam int NS = NUM_UNITS + 1;
  localparam int SW = $clog2(NS);

  logic [3:0]               op4;
  logic [SW-1:0]            tgt;
  logic                     accept, handshake;
  logic [NS-1:0]            slot_idle, slot_hold, slot_start, slot_drain;
  logic [TAG_LEN-1:0]       slot_tag    [NS];
  logic [OP_LEN-1:0]        slot_op     [NS];
  logic [PRECISION_LEN-1:0] slot_result [NS];
  logic [NS-1:0]            slot_err;

  logic [SW-1:0]            rr_ptr, rr_grant, grant, lock_idx;
  logic                     rr_found, res_lock;
  int                       idx;

  assign op4       = cmd_op[3:0];
  assign tgt       = is_legal_op(op4) ? SW'(op_to_unit(op4)) : SW'(NUM_UNITS);
  assign cmd_ready = !srst && (op4 == OP_IDLE || slot_idle[tgt]);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = ~slot_idle[NUM_UNITS-1:0];

  always_comb begin
    slot_start = '0;
    slot_drain = '0;
    for (int i = 0; i < NS; i++) begin
      slot_start[i] = accept && (op4 != OP_IDLE) && (tgt == SW'(i));
      slot_drain[i] = handshake && (grant == SW'(i));
    end
  end

  for (genvar i = 0; i < NS; i++) begin : g_slot
    logic                     v;
    logic [PRECISION_LEN-1:0] r;
    if (i < NUM_UNITS) begin : g_unit
      assign v = unit_valid[i];
      assign r = unit_result[i*PRECISION_LEN +: PRECISION_LEN];
    end else begin : g_err
      assign v = 1'b0;
      assign r = '0;
    end
    fpu_slot #(
      .PRECISION_LEN(PRECISION_LEN),
      .OP_LEN       (OP_LEN),
      .TAG_LEN      (TAG_LEN),
      .TIMEOUT      (TIMEOUT),
      .HAS_RUN      (i < NUM_UNITS)
    ) u_slot (
      .clk        (clk),
      .srst       (srst),
      .start      (slot_start[i]),
      .start_tag  (cmd_tag),
      .start_op   (cmd_op),
      .unit_valid (v),
      .unit_result(r),
      .drain      (slot_drain[i]),
      .idle       (slot_idle[i]),
      .hold       (slot_hold[i]),
      .tag        (slot_tag[i]),
      .op         (slot_op[i]),
      .result     (slot_result[i]),
      .err        (slot_err[i])
    );
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      unit_enable <= '0;
      unit_op     <= '0;
      unit_a      <= '0;
      unit_b      <= '0;
    end else begin
      unit_enable <= slot_start[NUM_UNITS-1:0];
      if (|slot_start[NUM_UNITS-1:0]) begin
        unit_op <= cmd_op;
        unit_a  <= cmd_a;
        unit_b  <= cmd_b;
      end
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    idx      = 0;
    for (int k = 0; k < NS; k++) begin
      idx = (int'(rr_ptr) + k) % NS;
      if (!rr_found && slot_hold[idx]) begin
        rr_found = 1'b1;
        rr_grant = SW'(idx);
      end
    end
  end

  // A stalled grant is frozen so a slot finishing later cannot reorder the presented result.
  assign grant     = res_lock ? lock_idx : rr_grant;
  assign res_valid = res_lock || rr_found;
  assign handshake = res_valid && res_ready;

  always_comb begin
    res_data = '0;
    res_tag  = '0;
    res_op   = '0;
    res_err  = 1'b0;
    if (res_valid) begin
      res_data = slot_result[grant];
      res_tag  = slot_tag[grant];
      res_op   = slot_op[grant];
      res_err  = slot_err[grant];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rr_ptr   <= '0;
      res_lock <= 1'b0;
      lock_idx <= '0;
    end else if (handshake) begin
      rr_ptr   <= (grant == SW'(NS - 1)) ? '0 : grant + 1'b1;
      res_lock <= 1'b0;
    end else if (res_valid) begin
      res_lock <= 1'b1;
      lock_idx <= grant;
    end
  end

endmodule

// File: tb/tb_fpu_dispatch_ctrl.sv
// Directed bench for fpu_dispatch_ctrl with a round-robin-aware result scoreboard.
module tb_fpu_dispatch_ctrl;

  localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] THREE = 64'h4008_0000_0000_0000;
  localparam logic [63:0] SIX   = 64'h4018_0000_0000_0000;
  localparam logic [63:0] QN    = 64'h7FF8_0000_0000_0000;

  logic          clk = 1'b0;
  logic          srst;
  logic          cmd_valid, cmd_ready;
  logic [3:0]    cmd_op, cmd_tag;
  logic [63:0]   cmd_a, cmd_b;
  logic [6:0]    unit_enable;
  logic [3:0]    unit_op;
  logic [63:0]   unit_a, unit_b;
  logic [6:0]    unit_valid;
  logic [447:0]  unit_result;
  logic          res_valid, res_ready;
  logic [63:0]   res_data;
  logic [3:0]    res_tag, res_op;
  logic          res_err;
  logic [6:0]    busy;

  always #5 clk = ~clk;

  fpu_dispatch_ctrl dut (
    .clk(clk), .srst(srst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .unit_enable(unit_enable), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_valid(unit_valid), .unit_result(unit_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_op(res_op), .res_err(res_err), .busy(busy)
  );

  typedef struct {
    int          slot;
    logic [3:0]  tag;
    logic [3:0]  op;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_rr = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] tag, input logic [63:0] a, input logic [63:0] b);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_tag = tag; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL send_accept observed=not_ready expected=ready op=%0d", op);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, 64'(exp_q.size()), 64'd0);
    step();
  endtask

  function automatic int pick();
    int best = -1;
    int bestd = 99;
    int d;
    foreach (exp_q[i]) begin
      d = (exp_q[i].slot - m_rr + 8) % 8;
      if (d < bestd) begin bestd = d; best = i; end
    end
    return best;
  endfunction

  logic        prev_stall = 1'b0;
  logic [63:0] p_data;
  logic [3:0]  p_tag, p_op;
  logic        p_err;

  always @(negedge clk) begin
    int   k;
    exp_t e;
    if (srst) begin
      prev_stall = 1'b0;
      m_rr = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        assert (res_valid === 1'b1 && res_data === p_data && res_tag === p_tag &&
                res_op === p_op && res_err === p_err) else begin
          failures++;
          $error("FAIL hold_stable observed=%0h/%0h/%0h expected=%0h/%0h/%0h",
                 res_data, res_tag, res_op, p_data, p_tag, p_op);
        end
      end
      if (res_valid && res_ready) begin
        k = pick();
        checks++;
        assert (k >= 0) else begin
          failures++;
          $error("FAIL unexpected_result observed=tag%0d expected=no_result", res_tag);
        end
        if (k >= 0) begin
          e = exp_q[k];
          exp_q.delete(k);
          m_rr = (e.slot + 1) % 8;
          checks++;
          assert ({res_data, res_tag, res_op, res_err} === {e.data, e.tag, e.op, e.err}) else begin
            failures++;
            $error("FAIL result observed=%0h/t%0d/o%0d/e%0b expected=%0h/t%0d/o%0d/e%0b",
                   res_data, res_tag, res_op, res_err, e.data, e.tag, e.op, e.err);
          end
        end
      end
      prev_stall = res_valid && !res_ready;
      p_data = res_data; p_tag = res_tag; p_op = res_op; p_err = res_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_tag = '0; cmd_a = '0; cmd_b = '0;
    unit_valid = '0; unit_result = '0; res_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_enable", 64'(unit_enable), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_res_tag", 64'(res_tag), 64'd0);
    step(); srst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // ADD 1.0 + 2.0, unit answers two cycles after enable
    step(); res_ready = 1'b1;
    send(4'd1, 4'd3, ONE, TWO);
    @(negedge clk);
    chk("add_enable", 64'(unit_enable), 64'h01);
    chk("add_unit_op", 64'(unit_op), 64'd1);
    chk("add_unit_a", unit_a, ONE);
    chk("add_unit_b", unit_b, TWO);
    chk("add_busy", 64'(busy), 64'h01);
    step();
    @(negedge clk);
    chk("add_enable_pulse", 64'(unit_enable), 64'd0);
    step();
    unit_valid = 7'b0000001; unit_result[0 +: 64] = THREE;
    exp_q.push_back('{0, 4'd3, 4'd1, THREE, 1'b0});
    @(negedge clk);
    chk("add_no_early", 64'(res_valid), 64'd0);
    step(); unit_valid = '0;
    wait_drain("add_drain");
    chk("add_busy_clear", 64'(busy), 64'd0);

    // DIV then MUL; MUL completes first and retires first
    send(4'd4, 4'd1, TWO, ONE);
    @(negedge clk);
    chk("div_enable", 64'(unit_enable), 64'h04);
    step();
    send(4'd3, 4'd2, THREE, TWO);
    @(negedge clk);
    chk("mul_enable", 64'(unit_enable), 64'h02);
    chk("divmul_busy", 64'(busy), 64'h06);
    step();
    unit_valid = 7'b0000010; unit_result[64 +: 64] = SIX;
    exp_q.push_back('{1, 4'd2, 4'd3, SIX, 1'b0});
    step(); unit_valid = '0;
    wait_drain("mul_drain");
    chk("div_busy_mid", 64'(busy), 64'h04);
    unit_valid = 7'b0000100; unit_result[128 +: 64] = TWO;
    exp_q.push_back('{2, 4'd1, 4'd4, TWO, 1'b0});
    step(); unit_valid = '0;
    wait_drain("div_drain");
    chk("divmul_busy_clear", 64'(busy), 64'd0);

    // second DIV blocked until the first one drains
    send(4'd4, 4'd6, ONE, ONE);
    res_ready = 1'b0;
    unit_valid = 7'b0000100; unit_result[128 +: 64] = ONE;
    exp_q.push_back('{2, 4'd6, 4'd4, ONE, 1'b0});
    step(); unit_valid = '0;
    cmd_valid = 1'b1; cmd_op = 4'd4; cmd_tag = 4'd7; cmd_a = THREE; cmd_b = ONE;
    @(negedge clk);
    chk("div2_blocked", 64'(cmd_ready), 64'd0);
    repeat (3) begin
      step();
      @(negedge clk);
      chk("div2_blocked_hold", 64'(cmd_ready), 64'd0);
    end
    step(); res_ready = 1'b1;
    @(negedge clk);
    chk("div2_blocked_at_hs", 64'(cmd_ready), 64'd0);
    step();
    @(negedge clk);
    chk("div2_ready_after_drain", 64'(cmd_ready), 64'd1);
    step(); cmd_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    chk("div2_enable", 64'(unit_enable), 64'h04);
    chk("div2_unit_op", 64'(unit_op), 64'd4);
    chk("div2_unit_a", unit_a, THREE);

    // that DIV never completes: timeout after TIMEOUT+1 run cycles
    exp_q.push_back('{2, 4'd7, 4'd4, QN, 1'b1});
    repeat (63) step();
    @(negedge clk);
    chk("to_not_early", 64'(res_valid), 64'd0);
    step();
    @(negedge clk);
    chk("to_valid", 64'(res_valid), 64'd1);
    chk("to_err", 64'(res_err), 64'd1);
    chk("to_data", res_data, QN);
    chk("to_busy", 64'(busy), 64'h04);
    step(); res_ready = 1'b1;
    wait_drain("to_drain");
    chk("to_busy_clear", 64'(busy), 64'd0);
    unit_valid = 7'b0000100; unit_result[128 +: 64] = ONE;
    step(); unit_valid = '0;
    @(negedge clk);
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_res_valid", 64'(res_valid), 64'd0);

    // illegal opcode goes straight to the error slot
    step(); res_ready = 1'b0;
    exp_q.push_back('{7, 4'd5, 4'd12, QN, 1'b1});
    send(4'd12, 4'd5, ONE, ONE);
    @(negedge clk);
    chk("ill_valid", 64'(res_valid), 64'd1);
    chk("ill_err", 64'(res_err), 64'd1);
    chk("ill_op", 64'(res_op), 64'd12);
    chk("ill_tag", 64'(res_tag), 64'd5);
    chk("ill_data", res_data, QN);
    chk("ill_enable", 64'(unit_enable), 64'd0);
    step(); cmd_valid = 1'b1; cmd_op = 4'd13;
    @(negedge clk);
    chk("ill_blocked", 64'(cmd_ready), 64'd0);
    step(); cmd_valid = 1'b0; res_ready = 1'b1;
    wait_drain("ill_drain");

    // IDLE opcode: accepted, no activity
    send(4'd0, 4'd9, ONE, ONE);
    @(negedge clk);
    chk("nop_enable", 64'(unit_enable), 64'd0);
    step(); step();
    @(negedge clk);
    chk("nop_no_res", 64'(res_valid), 64'd0);
    chk("nop_busy", 64'(busy), 64'd0);

    // SIN, LOG, SQR complete together under backpressure
    step(); res_ready = 1'b0;
    send(4'd5, 4'd10, ONE, ONE);
    send(4'd7, 4'd11, ONE, ONE);
    send(4'd9, 4'd12, ONE, ONE);
    @(negedge clk);
    chk("trio_busy", 64'(busy), 64'h58);
    step();
    unit_valid = 7'b1011000;
    unit_result[192 +: 64] = ONE; unit_result[256 +: 64] = TWO; unit_result[384 +: 64] = SIX;
    exp_q.push_back('{3, 4'd10, 4'd5, ONE, 1'b0});
    exp_q.push_back('{4, 4'd11, 4'd7, TWO, 1'b0});
    exp_q.push_back('{6, 4'd12, 4'd9, SIX, 1'b0});
    step(); unit_valid = '0;
    @(negedge clk);
    chk("trio_first_tag", 64'(res_tag), 64'd10);
    repeat (5) step();
    @(negedge clk);
    chk("trio_still_first", 64'(res_tag), 64'd10);
    step(); res_ready = 1'b1;
    wait_drain("trio_drain");
    chk("trio_busy_clear", 64'(busy), 64'd0);

    // reset while EXP is running aborts silently
    send(4'd8, 4'd13, ONE, ONE);
    step(); srst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 64'(cmd_ready), 64'd0);
    step(); srst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_res_valid", 64'(res_valid), 64'd0);
    chk("rst_mid_enable", 64'(unit_enable), 64'd0);
    step();
    unit_valid = 7'b0100000; unit_result[320 +: 64] = ONE;
    step(); unit_valid = '0;
    repeat (3) step();
    @(negedge clk);
    chk("late_res_valid", 64'(res_valid), 64'd0);
    chk("late_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
